// File: rtl/cpu_mem_pkg.sv
// Shared types and widths for the CPU main-memory port arbiter.
package cpu_mem_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_D = 2'd1,
    ST_SERVE_I = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } mem_op_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between instruction fetch and data access,
// data first with a streak limit so fetch cannot starve.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_read,
  input  logic [WORD_W-1:0] inst_addr,
  output logic [WORD_W-1:0] inst_rdata,
  output logic              inst_busywait,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [WORD_W-1:0] data_addr,
  input  logic [WORD_W-1:0] data_wdata,
  output logic [WORD_W-1:0] data_rdata,
  output logic              data_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_e          r_state,      w_state_nxt;
  mem_op_e             r_op,         w_op_nxt;
  logic                r_mem_read,   w_mem_read_nxt;
  logic                r_mem_write,  w_mem_write_nxt;
  logic [WORD_W-1:0]   r_addr,       w_addr_nxt;
  logic [WORD_W-1:0]   r_wdata,      w_wdata_nxt;
  logic [STREAK_W-1:0] r_streak,     w_streak_nxt;
  logic [WORD_W-1:0]   r_inst_rdata, w_inst_rdata_nxt;
  logic [WORD_W-1:0]   r_data_rdata, w_data_rdata_nxt;

  logic w_data_req;
  logic w_grant_d;
  logic w_grant_i;

  assign w_data_req = data_read | data_write;
  assign w_grant_d  = w_data_req & (~inst_read | (r_streak != STREAK_MAX));
  assign w_grant_i  = inst_read & ~w_grant_d;

  // State and latched transaction registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_NONE;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_streak     <= '0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_mem_read   <= w_mem_read_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_streak     <= w_streak_nxt;
      r_inst_rdata <= w_inst_rdata_nxt;
      r_data_rdata <= w_data_rdata_nxt;
    end
  end

  // Arbitration, grant latching and completion
  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_mem_read_nxt   = r_mem_read;
    w_mem_write_nxt  = r_mem_write;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_streak_nxt     = r_streak;
    w_inst_rdata_nxt = r_inst_rdata;
    w_data_rdata_nxt = r_data_rdata;

    case (r_state)
      ST_IDLE: begin
        if (!inst_read) begin
          w_streak_nxt = '0;
        end
        if (w_grant_d) begin
          w_state_nxt     = ST_SERVE_D;
          w_op_nxt        = data_write ? OP_WRITE : OP_READ;
          w_mem_read_nxt  = ~data_write;
          w_mem_write_nxt = data_write;
          w_addr_nxt      = data_addr;
          w_wdata_nxt     = data_wdata;
          if (inst_read && (r_streak != STREAK_MAX)) begin
            w_streak_nxt = r_streak + STREAK_W'(1);
          end
        end else if (w_grant_i) begin
          w_state_nxt     = ST_SERVE_I;
          w_op_nxt        = OP_READ;
          w_mem_read_nxt  = 1'b1;
          w_mem_write_nxt = 1'b0;
          w_addr_nxt      = inst_addr;
          w_streak_nxt    = '0;
        end
      end
      ST_SERVE_D, ST_SERVE_I: begin
        if (mem_ready) begin
          w_state_nxt     = ST_IDLE;
          w_op_nxt        = OP_NONE;
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
          // Read data lands even if the requester has since been flushed
          if (r_op == OP_READ) begin
            if (r_state == ST_SERVE_I) begin
              w_inst_rdata_nxt = mem_rdata;
            end else begin
              w_data_rdata_nxt = mem_rdata;
            end
          end
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_op_nxt        = OP_NONE;
        w_mem_read_nxt  = 1'b0;
        w_mem_write_nxt = 1'b0;
      end
    endcase
  end

  // Stalls drop in the completion cycle so the pipeline advances on that edge
  assign inst_busywait = rst & inst_read  & ~((r_state == ST_SERVE_I) & mem_ready);
  assign data_busywait = rst & w_data_req & ~((r_state == ST_SERVE_D) & mem_ready);

  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign inst_rdata = r_inst_rdata;
  assign data_rdata = r_data_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single main-memory port between instruction fetch (IF stage) and data access (MEM stage).
- Converts each requester's level request into one memory transaction and returns read data.
- Drives a per-requester `busywait` that freezes the upstream pipeline registers until that requester's access completes.
- Gives data priority, with a streak limit so instruction fetch is never starved.

## Interface
Parameters:
- `MAX_DATA_STREAK`, default 4: consecutive data grants allowed while `inst_read` is pending; range 1–15.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `inst_read`  in  1  IF read request, level.
- `inst_addr`  in  32  IF word address.
- `inst_rdata`  out  32  fetched instruction.
- `inst_busywait`  out  1  IF stall.
- `data_read`  in  1  MEM-stage load request.
- `data_write`  in  1  MEM-stage store request.
- `data_addr`  in  32  data address.
- `data_wdata`  in  32  store data.
- `data_rdata`  out  32  load data.
- `data_busywait`  out  1  MEM-stage stall; also freezes the EX/MEM register.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `mem_addr`  out  32  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data, valid when `mem_ready` is high.
- `mem_ready`  in  1  one-cycle completion pulse.

## Operation
**FSM states:** IDLE, SERVE_D, SERVE_I.

**IDLE**
- Samples requests. A data request is `data_read | data_write`.
- If both requesters ask: grant data unless `streak == MAX_DATA_STREAK`; in that case grant instruction.
- On grant, latch into registers: address, write data, and op. If `data_read` and `data_write` are both high, the op is write.
- Next state is SERVE_D or SERVE_I.

**SERVE_x**
- `mem_read` or `mem_write` is held high from the latched op, with latched `mem_addr` and `mem_wdata`.
- State holds until `mem_ready`.
- On `mem_ready`:
  - Drop strobes at the next edge and return to IDLE.
  - For a read, register `mem_rdata` into `inst_rdata` or `data_rdata`. This output is held until the next completed read for that requester.

**busywait (combinational)**
- `x_busywait = x_req & ~(state == SERVE_x & mem_ready)`.
- It is therefore high in the IDLE sampling cycle and through the whole service, and low in the completion cycle.
- A requester's busywait stays high while the other requester is being served.

**Streak counter (4 bits)**
- Increments on each data grant made while `inst_read` is high.
- Clears on an instruction grant, and in any IDLE cycle with `inst_read` low.
- Saturates at `MAX_DATA_STREAK`.

**Boundary rules**
- A started transaction always completes. If the requester drops its request mid-service (flush), the access finishes, `rdata` still updates, and `busywait` is irrelevant.
- A request still high in the cycle after completion is a new request; IDLE re-arbitrates it.
- `mem_ready` seen in IDLE is ignored.
- Reset asserted mid-transaction:
  - Immediately forces IDLE, strobes low, and streak 0.
  - The memory-side abort is the memory's responsibility.

## Timing
- Reset values: `mem_read` 0, `mem_write` 0, `mem_addr` 0, `mem_wdata` 0, `inst_rdata` 0, `data_rdata` 0, state IDLE, streak 0.
- Both busywaits are forced to 0 while `rst` is low.
- Request first seen in cycle N (IDLE): strobes are high from cycle N+1.
- With `mem_ready` in cycle N+L (L ≥ 1): busywait goes low in cycle N+L, and `rdata` is valid after edge N+L.
- Minimum occupancy is 2 cycles per access.
- Back-to-back from one requester: the next request is sampled in cycle N+L+1 (IDLE).
- A losing requester waits the full service of the winner plus one IDLE cycle.
- Strobes, address and write data are glitch-free: register outputs only.

## Structure
- Shared package `cpu_mem_pkg`:
  - arbiter state enum (IDLE / SERVE_D / SERVE_I);
  - op encoding (NONE / READ / WRITE);
  - `WORD_W = 32`.
- No sub-module: the FSM, latch registers and streak counter stay in one module.

## Test plan
1. Data load only, `data_addr = 0x100`, memory L = 3: `mem_read` high for cycles N+1..N+3; `data_busywait` high N..N+2, low N+3; `data_rdata = 0xDEADBEEF` after edge N+3.
2. Simultaneous `inst_read` (0x0) and `data_write` (0x200, 0x12345678): data served first with `mem_write`, `mem_wdata = 0x12345678`; instruction served next; `inst_busywait` high throughout the first service.
3. Continuous data requests with `inst_read` held, `MAX_DATA_STREAK = 4`: exactly 4 data grants, then an instruction grant, then the streak restarts.
4. `data_read` and `data_write` both high: a write is issued and `data_rdata` is unchanged.
5. Reset asserted in SERVE_I mid-wait: strobes fall immediately (asynchronous), outputs take reset values, and a later stray `mem_ready` in IDLE causes no grant or `rdata` update.
